// File: rtl/fp_addmul_unit_if.sv
// Operand/result valid-ready bundle between issue, fp_addmul_unit and writeback.
interface fp_addmul_unit_if #(parameter int EXP_W = 8, parameter int MANT_W = 23);
  localparam int W = 1 + EXP_W + MANT_W;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result, flags);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_addmul_unit.sv
// Multi-cycle IEEE add/sub/mul, RNE rounding, flush-to-zero, one op in flight.
module fp_addmul_unit #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic             clock,
  input  logic             reset,
  fp_addmul_unit_if.slave  io
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int M1 = MANT_W + 1;   // significand with hidden bit
  localparam int SW = MANT_W + 3;   // significand + guard + round
  localparam int XW = MANT_W + 4;   // ... + sticky
  localparam int MW = MANT_W + 5;   // ... + carry-out
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_MUL, S_NORM, S_ROUND, S_OUTPUT
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0]     ea_q, ea_d, eb_q, eb_d;
  logic [M1-1:0]        ma_q, ma_d, mb_q, mb_d;
  logic [3:0]           cla_q, cla_d, clb_q, clb_d;  // {nan, snan, inf, zero}
  logic [XW-1:0]        xl_q, xl_d, xs_q, xs_d;
  logic                 esub_q, esub_d;
  logic                 sgn_q, sgn_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [MW-1:0]        man_q, man_d;
  logic [W-1:0]         res_q, res_d;
  logic [3:0]           flg_q, flg_d;

  logic                 a_big, inc, grs, sp_hit;
  logic [EXP_W-1:0]     dexp;
  logic [2*SW-1:0]      wide;
  logic [2*M1-1:0]      prod;
  logic [M1:0]          rsig;
  logic signed [EW-1:0] rexp;
  logic [W-1:0]         sp_res;
  logic [3:0]           sp_flg;
  int                   lz;

  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic e1, e0, f0;
    e1 = &x[W-2:MANT_W];
    e0 = ~|x[W-2:MANT_W];
    f0 = ~|x[MANT_W-1:0];
    // exp==0 covers subnormals too: they are flushed to signed zero
    return {e1 & ~f0, e1 & ~f0 & ~x[MANT_W-1], e1 & f0, e0};
  endfunction

  function automatic int lzc(input logic [MW-2:0] v);
    int n;
    n = MW - 1;
    for (int i = 0; i < MW - 1; i++) if (v[i]) n = MW - 2 - i;
    return n;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
    op_q <= op_d;   a_q <= a_d;     b_q <= b_d;
    sa_q <= sa_d;   sb_q <= sb_d;   ea_q <= ea_d;   eb_q <= eb_d;
    ma_q <= ma_d;   mb_q <= mb_d;   cla_q <= cla_d; clb_q <= clb_d;
    xl_q <= xl_d;   xs_q <= xs_d;   esub_q <= esub_d;
    sgn_q <= sgn_d; exp_q <= exp_d; man_q <= man_d;
  end

  always_comb begin
    state_d = state_q; op_d = op_q; a_d = a_q; b_d = b_q;
    sa_d = sa_q; sb_d = sb_q; ea_d = ea_q; eb_d = eb_q;
    ma_d = ma_q; mb_d = mb_q; cla_d = cla_q; clb_d = clb_q;
    xl_d = xl_q; xs_d = xs_q; esub_d = esub_q;
    sgn_d = sgn_q; exp_d = exp_q; man_d = man_q;
    res_d = res_q; flg_d = flg_q;
    a_big = 1'b0; inc = 1'b0; grs = 1'b0; sp_hit = 1'b1;
    dexp = '0; wide = '0; prod = '0; rsig = '0; rexp = '0; lz = 0;
    sp_res = QNAN; sp_flg = 4'b0000;
    case (state_q)
      S_IDLE: if (io.in_valid) begin
        a_d = io.a; b_d = io.b; op_d = io.op;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        cla_d = classify(a_q);
        clb_d = classify(b_q);
        sa_d  = a_q[W-1];
        sb_d  = b_q[W-1] ^ (op_q == 2'b01);
        ea_d  = a_q[W-2:MANT_W];
        eb_d  = b_q[W-2:MANT_W];
        ma_d  = cla_d[0] ? '0 : {1'b1, a_q[MANT_W-1:0]};
        mb_d  = clb_d[0] ? '0 : {1'b1, b_q[MANT_W-1:0]};
        state_d = S_SPECIAL;
      end
      S_SPECIAL: begin
        if (op_q == 2'b11) sp_flg = 4'b1000;
        else if (cla_q[3] | clb_q[3]) sp_flg = {cla_q[2] | clb_q[2], 3'b000};
        else if (op_q != 2'b10) begin
          if (cla_q[1] & clb_q[1] & (sa_q != sb_q)) sp_flg = 4'b1000;
          else if (cla_q[1])              sp_res = {sa_q, INF};
          else if (clb_q[1])              sp_res = {sb_q, INF};
          else if (cla_q[0] & clb_q[0])   sp_res = {sa_q & sb_q, {(W-1){1'b0}}};
          else if (cla_q[0])              sp_res = {sb_q, b_q[W-2:0]};
          else if (clb_q[0])              sp_res = a_q;
          else                            sp_hit = 1'b0;
        end else begin
          if ((cla_q[1] & clb_q[0]) | (clb_q[1] & cla_q[0])) sp_flg = 4'b1000;
          else if (cla_q[1] | clb_q[1])   sp_res = {sa_q ^ sb_q, INF};
          else if (cla_q[0] | clb_q[0])   sp_res = {sa_q ^ sb_q, {(W-1){1'b0}}};
          else                            sp_hit = 1'b0;
        end
        if (sp_hit) begin
          res_d = sp_res; flg_d = sp_flg; state_d = S_OUTPUT;
        end else begin
          state_d = (op_q == 2'b10) ? S_MUL : S_ALIGN;
        end
      end
      S_ALIGN: begin
        a_big  = {ea_q, ma_q} >= {eb_q, mb_q};
        sgn_d  = a_big ? sa_q : sb_q;
        exp_d  = {2'b00, a_big ? ea_q : eb_q};
        dexp   = a_big ? ea_q - eb_q : eb_q - ea_q;
        xl_d   = {a_big ? ma_q : mb_q, 3'b000};
        esub_d = sa_q ^ sb_q;
        if (int'(dexp) >= MANT_W + 3) xs_d = {{(XW-1){1'b0}}, 1'b1};
        else begin
          wide = {a_big ? mb_q : ma_q, 2'b00, {SW{1'b0}}} >> dexp;
          xs_d = {wide[2*SW-1:SW], |wide[SW-1:0]};
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        man_d   = esub_q ? {1'b0, xl_q} - {1'b0, xs_q} : {1'b0, xl_q} + {1'b0, xs_q};
        state_d = S_NORM;
      end
      S_MUL: begin
        prod    = {{M1{1'b0}}, ma_q} * {{M1{1'b0}}, mb_q};
        man_d   = {prod[2*M1-1:MANT_W], prod[MANT_W-1], prod[MANT_W-2], |prod[MANT_W-3:0]};
        exp_d   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS;
        sgn_d   = sa_q ^ sb_q;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (man_q[MW-1]) begin
          man_d = {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
          exp_d = exp_q + EW'(1);
        end else begin
          lz    = lzc(man_q[MW-2:0]);
          man_d = man_q << lz;
          exp_d = exp_q - EW'(lz);
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        inc  = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
        grs  = |man_q[2:0];
        rsig = {1'b0, man_q[MW-2:3]} + {{M1{1'b0}}, inc};
        rexp = exp_q;
        if (rsig[M1]) begin
          rsig = rsig >> 1;
          rexp = exp_q + EW'(1);
        end
        if (man_q == '0) begin
          res_d = '0; flg_d = 4'b0000;
        end else if (rexp >= EMAX) begin
          res_d = {sgn_q, INF}; flg_d = 4'b0101;
        end else if (rexp <= 0) begin
          res_d = {sgn_q, {(W-1){1'b0}}}; flg_d = 4'b0011;
        end else begin
          res_d = {sgn_q, rexp[EXP_W-1:0], rsig[MANT_W-1:0]}; flg_d = {3'b000, grs};
        end
        state_d = S_OUTPUT;
      end
      S_OUTPUT: if (io.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_OUTPUT);
  assign io.result    = res_q;
  assign io.flags     = flg_q;
endmodule

// File: tb/tb_fp_addmul_unit.sv
// Scoreboard bench: single and half precision instances, handshake and reset scenarios.
module tb_fp_addmul_unit;
  logic clock, reset;
  int   errors, checks;

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;
  vec_t sb[$];

  fp_addmul_unit_if #(.EXP_W(8), .MANT_W(23)) i32 ();
  fp_addmul_unit_if #(.EXP_W(5), .MANT_W(10)) i16 ();

  fp_addmul_unit #(.EXP_W(8), .MANT_W(23)) u_sp (.clock(clock), .reset(reset), .io(i32));
  fp_addmul_unit #(.EXP_W(5), .MANT_W(10)) u_hp (.clock(clock), .reset(reset), .io(i16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [1:0] op,
                              logic [31:0] res, logic [3:0] flg, int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.flg = flg; v.lat = lat;
    return v;
  endfunction

  // Push expectation, issue on an idle unit, return what came out and after how many edges.
  task automatic xact32(input vec_t v, output logic [31:0] r, output logic [3:0] f, output int lat);
    sb.push_back(v);
    @(negedge clock);
    i32.in_valid = 1'b1; i32.a = v.a; i32.b = v.b; i32.op = v.op; i32.out_ready = 1'b0;
    @(posedge clock);
    #1 i32.in_valid = 1'b0;
    lat = 0;
    while (i32.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clock); #1; lat++;
    end
    r = i32.result; f = i32.flags;
    @(negedge clock); i32.out_ready = 1'b1;
    @(negedge clock); i32.out_ready = 1'b0;
  endtask

  task automatic xact16(input vec_t v, output logic [31:0] r, output logic [3:0] f, output int lat);
    sb.push_back(v);
    @(negedge clock);
    i16.in_valid = 1'b1; i16.a = v.a[15:0]; i16.b = v.b[15:0]; i16.op = v.op; i16.out_ready = 1'b0;
    @(posedge clock);
    #1 i16.in_valid = 1'b0;
    lat = 0;
    while (i16.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clock); #1; lat++;
    end
    r = {16'h0, i16.result}; f = i16.flags;
    @(negedge clock); i16.out_ready = 1'b1;
    @(negedge clock); i16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (i32.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", i32.in_ready); end
    checks++; if (i32.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", i32.out_valid); end
    checks++; if (i32.result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", i32.result); end
    checks++; if (i32.flags !== 4'h0) begin errors++; $display("FAIL reset flags: got %b want 0000", i32.flags); end
    reset = 1'b0;
  endtask

  task automatic test_addsub();
    vec_t v[6]; vec_t e; logic [31:0] r; logic [3:0] f; int lat;
    v[0] = mk(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 6);
    v[1] = mk(32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 4'b0000, 6);
    v[2] = mk(32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, 4'b0001, 6);
    v[3] = mk(32'h3F800001, 32'h33800000, 2'b00, 32'h3F800002, 4'b0001, 6);
    v[4] = mk(32'h40400000, 32'hBF800000, 2'b00, 32'h40000000, 4'b0000, 6);
    v[5] = mk(32'h00000001, 32'h3F800000, 2'b00, 32'h3F800000, 4'b0000, 2);
    foreach (v[i]) begin
      xact32(v[i], r, f, lat);
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL addsub[%0d] result: got %h want %h", i, r, e.res); end
      checks++; if (f !== e.flg) begin errors++; $display("FAIL addsub[%0d] flags: got %b want %b", i, f, e.flg); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL addsub[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_mul();
    vec_t v[4]; vec_t e; logic [31:0] r; logic [3:0] f; int lat;
    v[0] = mk(32'h3FC00000, 32'h40000000, 2'b10, 32'h40400000, 4'b0000, 5);
    v[1] = mk(32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000, 4'b0101, 5);
    v[2] = mk(32'h00800000, 32'h3F000000, 2'b10, 32'h00000000, 4'b0011, 5);
    v[3] = mk(32'hC0000000, 32'h40400000, 2'b10, 32'hC0C00000, 4'b0000, 5);
    foreach (v[i]) begin
      xact32(v[i], r, f, lat);
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL mul[%0d] result: got %h want %h", i, r, e.res); end
      checks++; if (f !== e.flg) begin errors++; $display("FAIL mul[%0d] flags: got %b want %b", i, f, e.flg); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_special();
    vec_t v[5]; vec_t e; logic [31:0] r; logic [3:0] f; int lat;
    v[0] = mk(32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000, 4'b1000, 2);
    v[1] = mk(32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000, 2);
    v[2] = mk(32'h7F800000, 32'h00000000, 2'b10, 32'h7FC00000, 4'b1000, 2);
    v[3] = mk(32'h3F800000, 32'h3F800000, 2'b11, 32'h7FC00000, 4'b1000, 2);
    v[4] = mk(32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000, 2);
    foreach (v[i]) begin
      xact32(v[i], r, f, lat);
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL special[%0d] result: got %h want %h", i, r, e.res); end
      checks++; if (f !== e.flg) begin errors++; $display("FAIL special[%0d] flags: got %b want %b", i, f, e.flg); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_hold();
    vec_t e; int n;
    sb.push_back(mk(32'h3F800000, 32'h40000000, 2'b10, 32'h40000000, 4'b0000, 5));
    @(negedge clock);
    i32.in_valid = 1'b1; i32.a = 32'h3F800000; i32.b = 32'h40000000; i32.op = 2'b10; i32.out_ready = 1'b0;
    @(posedge clock);
    #1 i32.in_valid = 1'b0;
    @(negedge clock);
    i32.in_valid = 1'b1; i32.a = 32'h40400000; i32.b = 32'h40400000; i32.op = 2'b00;
    @(negedge clock);
    i32.in_valid = 1'b0;
    n = 0;
    while (i32.out_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    e = sb.pop_front();
    checks++; if (n >= 50) begin errors++; $display("FAIL hold timeout: out_valid not seen in %0d cycles", n); end
    repeat (10) begin
      @(negedge clock);
      checks++;
      if (i32.out_valid !== 1'b1 || i32.result !== e.res || i32.flags !== e.flg) begin
        errors++; $display("FAIL hold stable: valid=%b result=%h flags=%b want 1 %h %b",
                           i32.out_valid, i32.result, i32.flags, e.res, e.flg);
      end
      checks++; if (i32.in_ready !== 1'b0) begin errors++; $display("FAIL hold in_ready: got %b want 0", i32.in_ready); end
    end
    i32.out_ready = 1'b1;
    @(negedge clock);
    i32.out_ready = 1'b0;
    repeat (12) begin
      checks++;
      if (i32.out_valid !== 1'b0 || i32.in_ready !== 1'b1) begin
        errors++; $display("FAIL busy_ignore: out_valid=%b in_ready=%b want 0 1", i32.out_valid, i32.in_ready);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    vec_t e; logic [31:0] r; logic [3:0] f; int lat;
    @(negedge clock);
    i32.in_valid = 1'b1; i32.a = 32'h3F800000; i32.b = 32'h40000000; i32.op = 2'b00;
    @(posedge clock);
    #1 i32.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (i32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid: got %b want 0", i32.out_valid); end
    checks++; if (i32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid in_ready: got %b want 1", i32.in_ready); end
    @(negedge clock);
    reset = 1'b0;
    xact32(mk(32'h3FC00000, 32'h40000000, 2'b10, 32'h40400000, 4'b0000, 5), r, f, lat);
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL reset_mid next result: got %h want %h", r, e.res); end
    checks++; if (f !== e.flg) begin errors++; $display("FAIL reset_mid next flags: got %b want %b", f, e.flg); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL reset_mid next latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_half();
    vec_t v[2]; vec_t e; logic [31:0] r; logic [3:0] f; int lat;
    v[0] = mk(32'h3C00, 32'h4000, 2'b00, 32'h4200, 4'b0000, 6);
    v[1] = mk(32'h7BFF, 32'h4000, 2'b10, 32'h7C00, 4'b0101, 5);
    foreach (v[i]) begin
      xact16(v[i], r, f, lat);
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL half[%0d] result: got %h want %h", i, r, e.res); end
      checks++; if (f !== e.flg) begin errors++; $display("FAIL half[%0d] flags: got %b want %b", i, f, e.flg); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL half[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    i32.in_valid = 1'b0; i32.op = 2'b00; i32.a = '0; i32.b = '0; i32.out_ready = 1'b0;
    i16.in_valid = 1'b0; i16.op = 2'b00; i16.a = '0; i16.b = '0; i16.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    test_reset();
    test_addsub();
    test_mul();
    test_special();
    test_hold();
    test_reset_mid();
    test_half();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
